// File: rtl/led_cmd_pkg.sv
// Shared types and ASCII constants for the UART LED command parser.
package led_cmd_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GOT_L,
        S_GOT_IDX,
        S_GOT_MODE
    } state_e;

    // Response raised by the parser in a single cycle
    typedef struct packed {
        logic       vld;
        logic [7:0] data;
    } resp_t;

    localparam logic [7:0] CH_L    = 8'h4C;
    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_B    = 8'h42;
    localparam logic [7:0] CH_T    = 8'h54;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_ACK  = 8'h4B;
    localparam logic [7:0] CH_NAK  = 8'h45;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_1    = 8'h31;

    // BLINK toggles to OFF, not ON
    function automatic mode_e toggle_mode(input mode_e m);
        return (m == MODE_OFF) ? MODE_ON : MODE_OFF;
    endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Free-running half-period counter; phase flips each time it wraps.
module blink_prescaler #(
    parameter int CLK_HZ   = 12000000,
    parameter int BLINK_HZ = 2
) (
    input  logic clk,
    input  logic rstn,
    output logic phase
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CW'(HALF - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_cmd_parser.sv
// Parses framed "L<idx><mode><CR|LF>" commands into per-LED modes and
// answers each frame with a one-byte K/E response over valid/ready.
module led_cmd_parser
    import led_cmd_pkg::*;
#(
    parameter int NUM_LEDS = 3,
    parameter int CLK_HZ   = 12000000,
    parameter int BLINK_HZ = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    output logic [7:0]          tx_byte,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                resp_drop,
    output logic [NUM_LEDS-1:0] leds
);

    state_e     state_q, state_d;
    mode_e      mode_q [NUM_LEDS];
    mode_e      pend_q [NUM_LEDS];
    mode_e      pend_d [NUM_LEDS];
    logic [3:0] idx_q, idx_d;
    logic       all_q, all_d;
    logic       commit;
    resp_t      resp;
    logic       phase;

    logic [7:0] digit;
    logic       idx_ok;

    assign digit  = rx_byte - CH_0;
    assign idx_ok = (rx_byte >= CH_0) && (digit < 8'(NUM_LEDS));

    blink_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .BLINK_HZ(BLINK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rstn (rstn),
        .phase(phase)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        all_d   = all_q;
        pend_d  = pend_q;
        commit  = 1'b0;
        resp    = '0;
        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_byte == CH_L) state_d = S_GOT_L;
                end
                S_GOT_L: begin
                    if (idx_ok) begin
                        idx_d   = digit[3:0];
                        all_d   = 1'b0;
                        state_d = S_GOT_IDX;
                    end else if (rx_byte == CH_STAR) begin
                        all_d   = 1'b1;
                        state_d = S_GOT_IDX;
                    end else begin
                        resp    = '{vld: 1'b1, data: CH_NAK};
                        state_d = S_IDLE;
                    end
                end
                S_GOT_IDX: begin
                    if (rx_byte inside {CH_0, CH_1, CH_B, CH_T}) begin
                        state_d = S_GOT_MODE;
                        // Toggle resolves against the mode held right now, per LED
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            case (rx_byte)
                                CH_0:    pend_d[i] = MODE_OFF;
                                CH_1:    pend_d[i] = MODE_ON;
                                CH_B:    pend_d[i] = MODE_BLINK;
                                default: pend_d[i] = toggle_mode(mode_q[i]);
                            endcase
                        end
                    end else begin
                        resp    = '{vld: 1'b1, data: CH_NAK};
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    if (rx_byte == CH_CR || rx_byte == CH_LF) begin
                        commit = 1'b1;
                        resp   = '{vld: 1'b1, data: CH_ACK};
                    end else begin
                        resp = '{vld: 1'b1, data: CH_NAK};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            all_q     <= 1'b0;
            leds      <= '0;
            tx_valid  <= 1'b0;
            tx_byte   <= '0;
            resp_drop <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= MODE_OFF;
                pend_q[i] <= MODE_OFF;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            all_q   <= all_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                pend_q[i] <= pend_d[i];
                if (commit && (all_q || idx_q == 4'(i))) mode_q[i] <= pend_q[i];
                leds[i] <= (mode_q[i] == MODE_ON) || ((mode_q[i] == MODE_BLINK) && phase);
            end
            // A pending byte wins unless it is being accepted this cycle
            resp_drop <= 1'b0;
            if (resp.vld) begin
                if (tx_valid && !tx_ready) begin
                    resp_drop <= 1'b1;
                end else begin
                    tx_valid <= 1'b1;
                    tx_byte  <= resp.data;
                end
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_cmd_parser.sv
// Directed bench for led_cmd_parser with a frame-level reference model.
module tb_led_cmd_parser;

    localparam int NUM  = 3;
    localparam int HALF = 5;

    logic           clk = 1'b0;
    logic           rstn;
    logic [7:0]     rx_byte;
    logic           rx_valid;
    logic [7:0]     tx_byte;
    logic           tx_valid;
    logic           tx_ready;
    logic           resp_drop;
    logic [NUM-1:0] leds;

    led_cmd_parser #(
        .NUM_LEDS(NUM),
        .CLK_HZ  (1000),
        .BLINK_HZ(100)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .resp_drop(resp_drop),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: modes as ints (0 off, 1 on, 2 blink), frame bytes seen so far
    int       md    [NUM];
    int       fmode [NUM];
    int       flen;
    int       fidx;
    bit       fall;
    int       n;
    bit       model_ok = 0;
    logic [NUM-1:0] el;
    bit       ev, ed;
    logic [7:0] eb;

    task automatic model_byte(input logic [7:0] b, output bit r, output logic [7:0] rb);
        r  = 0;
        rb = 8'h00;
        case (flen)
            0: if (b == "L") flen = 1;
            1: begin
                if (int'(b) >= 48 && int'(b) - 48 < NUM) begin
                    fall = 0; fidx = int'(b) - 48; flen = 2;
                end else if (b == "*") begin
                    fall = 1; flen = 2;
                end else begin
                    r = 1; rb = "E"; flen = 0;
                end
            end
            2: begin
                if (b == "0" || b == "1" || b == "B" || b == "T") begin
                    for (int i = 0; i < NUM; i++)
                        fmode[i] = (b == "0") ? 0 : (b == "1") ? 1 : (b == "B") ? 2 :
                                   (md[i] == 0) ? 1 : 0;
                    flen = 3;
                end else begin
                    r = 1; rb = "E"; flen = 0;
                end
            end
            default: begin
                flen = 0;
                r    = 1;
                if (b == 8'h0D || b == 8'h0A) begin
                    rb = "K";
                    for (int i = 0; i < NUM; i++)
                        if (fall || i == fidx) md[i] = fmode[i];
                end else begin
                    rb = "E";
                end
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        if (rstn) begin
            for (int i = 0; i < NUM; i++) md[i] = 0;
            flen = 0; n = 0; el = '0; ev = 0; eb = 8'h00; ed = 0;
            model_ok = 1;
        end else begin
            bit r;
            logic [7:0] rb;
            logic [NUM-1:0] nl;
            bit ph;
            ph = ((n / HALF) % 2) == 1;
            for (int i = 0; i < NUM; i++) nl[i] = (md[i] == 1) || (md[i] == 2 && ph);
            r = 0; rb = 0;
            if (rx_valid) model_byte(rx_byte, r, rb);
            ed = 0;
            if (r) begin
                if (ev && !tx_ready) ed = 1;
                else begin ev = 1; eb = rb; end
            end else if (ev && tx_ready) begin
                ev = 0;
            end
            el = nl;
            n++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("model_leds", 32'(leds), 32'(el));
            chk("model_tx_valid", 32'(tx_valid), 32'(ev));
            chk("model_resp_drop", 32'(resp_drop), 32'(ed));
            if (ev) chk("model_tx_byte", 32'(tx_byte), 32'(eb));
        end
    end

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int toggles;
        logic prev;
        rstn = 1'b1; tx_ready = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        chk("rst_leds", 32'(leds), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_resp_drop", 32'(resp_drop), 0);

        send_str("L1\r");
        chk("short_frame_valid", 32'(tx_valid), 1);
        chk("short_frame_byte", 32'(tx_byte), 32'h45);
        send_str("L11\r");
        chk("pre_commit_leds", 32'(leds), 0);
        chk("l11_byte", 32'(tx_byte), 32'h4B);
        step();
        chk("l11_leds", 32'(leds), 32'b010);

        send_str("L2B\n");
        repeat (3) step();
        prev = leds[2];
        toggles = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (leds[2] !== prev) toggles++;
            prev = leds[2];
        end
        chk("blink_toggles_20cyc", 32'(toggles), 4);
        send_str("L*0\r");
        chk("all_off_byte", 32'(tx_byte), 32'h4B);
        step();
        chk("all_off_leds", 32'(leds), 0);

        send_str("L5");
        chk("bad_idx_valid", 32'(tx_valid), 1);
        chk("bad_idx_byte", 32'(tx_byte), 32'h45);
        send_str("\n");
        chk("lf_after_err_silent", 32'(tx_valid), 0);

        tx_ready = 1'b0;
        send_str("L01\r");
        step();
        send_str("L00\r");
        chk("drop_pulse", 32'(resp_drop), 1);
        chk("pending_kept", 32'(tx_byte), 32'h4B);
        step();
        chk("drop_one_cycle", 32'(resp_drop), 0);
        chk("dropped_cmd_committed", 32'(leds[0]), 0);
        chk("still_pending", 32'(tx_valid), 1);
        tx_ready = 1'b1;
        step();
        chk("single_handshake", 32'(tx_valid), 0);

        send_str("L0B\r");
        repeat (12) step();
        send_str("L0T\r");
        step();
        chk("blink_toggle_off", 32'(leds[0]), 0);
        repeat (6) step();
        chk("blink_toggle_stays_off", 32'(leds[0]), 0);
        send_str("L0T\r");
        step();
        chk("off_toggle_on", 32'(leds[0]), 1);

        send_str("L21\r");
        step();
        chk("pre_reset_leds", 32'(leds), 32'b101);
        send_str("L1");
        rstn = 1'b1;
        step();
        rstn = 1'b0;
        chk("midframe_rst_leds", 32'(leds), 0);
        chk("midframe_rst_tx", 32'(tx_valid), 0);
        send_str("1\r");
        chk("post_rst_no_resp", 32'(tx_valid), 0);
        step();
        chk("post_rst_no_change", 32'(leds), 0);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/led_cmd_parser.md
Name: led_cmd_parser

Overview:
- UART-driven LED controller; successor to the single-byte LED parser.
- Accepts framed ASCII commands `L<idx><mode><CR|LF>` from the UART receiver and drives NUM_LEDS outputs, each independently set to off, on, or blink.
- Returns a one-byte acknowledgement ('K' or 'E') to the UART transmitter over a valid/ready handshake.
- Sits between uart_rx/uart_tx and the board LED pins.

Parameters:
- NUM_LEDS, 3, number of LED channels (1..10; index digits '0'..'9').
- CLK_HZ, 12000000, clock frequency in Hz.
- BLINK_HZ, 2, blink frequency; half-period = CLK_HZ/(2*BLINK_HZ) cycles (integer, >=2).

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous, active-high reset (reset asserted when rstn==1).
- rx_byte  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_byte valid.
- tx_byte  out  8  response byte.
- tx_valid  out  1  response pending.
- tx_ready  in  1  transmitter accepts tx_byte when tx_valid&&tx_ready.
- resp_drop  out  1  one-cycle pulse: a response was discarded because one was already pending.
- leds  out  NUM_LEDS  LED drive, active high, registered.

Behaviour:
- Reset (rstn==1 at posedge), overriding everything including in-flight frames:
  - all modes OFF, leds=0, parser IDLE.
  - tx_valid=0, tx_byte=0, resp_drop=0.
  - blink counter=0, blink phase=0.
- Mode encoding per LED (2 bits): OFF=0, ON=1, BLINK=2.
- Parser FSM; advances only on rx_valid cycles:
  - IDLE: 'L' -> GOT_L. CR(0x0D), LF(0x0A) and any other byte are ignored silently, with no response (so CRLF pairs are harmless).
  - GOT_L:
    - digit d with d<NUM_LEDS -> latch index d, GOT_IDX.
    - '*' -> latch "all", GOT_IDX.
    - anything else -> error.
  - GOT_IDX:
    - '0' -> OFF; '1' -> ON; 'B' -> BLINK.
    - 'T' -> toggle: OFF->ON, ON->OFF, BLINK->OFF.
    - Any of these latches the mode and goes to GOT_MODE; anything else -> error.
  - GOT_MODE:
    - CR or LF -> commit the mode to the indexed LED (or all LEDs), respond 'K', return to IDLE.
    - anything else -> error.
  - error: respond 'E' (0x45), return to IDLE. The offending byte is consumed; it is not re-parsed, even if it is 'L'.
- Commit latency: terminator on rx_valid in cycle t -> mode register updated at end of t -> leds reflect it at end of t+1.
  - leds[i] = (mode==ON) | (mode==BLINK & phase).
- Response latency: tx_valid=1 and tx_byte=0x4B/0x45 from cycle t+1.
  - Both held stable until the cycle where tx_ready==1; tx_valid clears on the following edge.
  - If a new response arises while tx_valid==1 and tx_ready==0, the new response is discarded, the pending byte is unchanged, and resp_drop pulses for 1 cycle.
  - If tx_ready==1 in the same cycle a new response arises, the new response replaces the old one and tx_valid stays 1 (no drop).
- The parser keeps accepting bytes while a response is pending; there is no backpressure on rx.
- Blink prescaler: free-running counter 0..HALF-1.
  - On wrap: counter->0 and phase toggles.
  - Phase is shared by all BLINK LEDs, so they blink in lockstep.
  - Commands do not reset the counter or phase.
- Simultaneous phase toggle and commit in the same cycle: both take effect; leds computed next cycle from the new mode and new phase.
- 'T' reads the mode register at the time the mode byte arrives, not at commit.
- For '*' with 'T', each LED toggles from its own current mode.

Decomposition:
- Package led_cmd_pkg:
  - mode enum {MODE_OFF, MODE_ON, MODE_BLINK}.
  - parser state enum {S_IDLE, S_GOT_L, S_GOT_IDX, S_GOT_MODE}.
  - ASCII constants: CH_L, CH_STAR, CH_B, CH_T, CH_CR, CH_LF, CH_ACK='K', CH_NAK='E'.
- One sub-module: blink_prescaler (params CLK_HZ, BLINK_HZ; ports clk, rstn, phase).

Test Plan (bench uses CLK_HZ=1000, BLINK_HZ=100, so HALF=5):
- After reset, send "L1\r" then "L11\r" (NUM_LEDS=3):
  - "L1\r": tx 'E' at the CR byte.
  - "L11\r": leds=3'b010 at t+2, tx 'K'.
  - leds=0 held throughout before the commit.
- Send "L2B\n":
  - leds[2] toggles every 5 cycles.
  - "L*0\r" then clears all: leds=0 at t+2, tx 'K'.
- Send "L5" with NUM_LEDS=3 -> 'E' immediately on the '5' byte. A following "\n" is ignored, with no second response.
- Hold tx_ready=0 and send "L01\r", then "L00\r":
  - first 'K' stays pending; second response dropped with resp_drop=1 for one cycle.
  - leds[0]=0 (second command still committed).
  - Raise tx_ready: a single 'K' handshake.
- Send "L0B\r", then "L0T\r" -> leds[0] goes BLINK then steady 0. Then "L0T\r" -> leds[0]=1.
- Assert rstn mid-frame after "L1" with leds=3'b101:
  - next cycle leds=0, tx_valid=0.
  - a following "1\r" yields no response and no change.
